// File: rtl/accel_entropy_pool.sv
// Accelerometer entropy pool: folds x/y LSB noise into a 32-bit
// Galois-mixed pool and hands out random bytes through a small FIFO.
module accel_entropy_pool #(
  parameter int COORD_WIDTH      = 16,
  parameter int SAMPLES_PER_BYTE = 4,
  parameter int REPEAT_LIMIT     = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   health_fail,
  output logic                   overrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [3:0] SPB = 4'(SAMPLES_PER_BYTE);
  localparam logic [7:0] LIM = 8'(REPEAT_LIMIT);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [31:0] TAPS = 32'hA300_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] pool;
  logic [3:0]  smp_cnt;
  logic [2:0]  mix_cnt;
  logic [7:0]  run_cnt;
  logic [7:0]  prev_raw;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        capture;
  logic        drop;
  logic        mix_en;
  logic        emit;
  logic        push;
  logic        pop;
  logic        full;
  logic [7:0]  raw;
  logic [31:0] pool_x;
  logic [31:0] pool_cap;
  logic [31:0] pool_mix;
  logic [7:0]  run_nxt;

  // Only x[7:4]/y[7:4] carry usable noise.
  logic unused_bits;
  assign unused_bits = ^{x[COORD_WIDTH-1:8], x[3:0],
                         y[COORD_WIDTH-1:8], y[3:0]};

  assign raw      = {x[7:4], y[7:4]};
  assign pool_x   = pool ^ {24'h0, raw};
  assign pool_cap = (pool_x == 32'h0) ? 32'h1 : pool_x;
  assign pool_mix = {1'b0, pool[31:1]} ^
                    (pool[0] ? TAPS : 32'h0);

  // Run length of identical raw bytes; 0 means nothing seen yet.
  always_comb begin
    run_nxt = 8'd1;
    if (run_cnt != 8'd0 && raw == prev_raw)
      run_nxt = (run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (sample_valid) state_nxt = MIX;
      MIX:
        if (mix_cnt == 3'd7)
          state_nxt = (smp_cnt == SPB) ? EMIT : IDLE;
      EMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    capture = 1'b0;
    drop    = 1'b0;
    mix_en  = 1'b0;
    emit    = 1'b0;
    unique case (state)
      IDLE: capture = sample_valid;
      MIX: begin
        mix_en = 1'b1;
        drop   = sample_valid;
      end
      EMIT: begin
        emit = 1'b1;
        drop = sample_valid;
      end
      default: ;
    endcase
  end

  // Pool mixing and sample/mix counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool    <= 32'h1;
      smp_cnt <= 4'd0;
      mix_cnt <= 3'd0;
    end else if (capture) begin
      pool    <= pool_cap;
      smp_cnt <= smp_cnt + 4'd1;
      mix_cnt <= 3'd0;
    end else if (mix_en) begin
      pool    <= pool_mix;
      mix_cnt <= mix_cnt + 3'd1;
    end else if (emit) begin
      smp_cnt <= 4'd0;
    end
  end

  // Repetition health test and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt     <= 8'd0;
      prev_raw    <= 8'd0;
      health_fail <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (capture) begin
        run_cnt  <= run_nxt;
        prev_raw <= raw;
        if (run_nxt >= LIM) health_fail <= 1'b1;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  assign full      = (count == DEPTH);
  assign push      = emit && !full && !health_fail;
  assign out_valid = (count != '0) && !health_fail;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

  // FIFO pointers/occupancy; a tripped health test keeps it flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (health_fail) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else if (push) begin
      mem[wr_ptr] <= pool[7:0];
    end
  end

endmodule

// File: tb/tb_accel_entropy_pool.sv
// Bench for accel_entropy_pool: directed samples against a
// byte-level model of pool mixing, FIFO and health test.
module tb_accel_entropy_pool;

  localparam int SPB = 4;
  localparam int LIM = 8;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        health_fail;
  logic        overrun;

  accel_entropy_pool #(
    .COORD_WIDTH(16),
    .SAMPLES_PER_BYTE(SPB),
    .REPEAT_LIMIT(LIM),
    .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_valid(sample_valid),
    .x(x),
    .y(y),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .health_fail(health_fail),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  logic [31:0] m_pool;
  int          m_cnt;
  int          m_run;
  logic [7:0]  m_prev;
  bit          m_fail;
  logic [7:0]  q[$];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mix8(logic [31:0] p);
    logic [31:0] r;
    r = p;
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ 32'hA300_0000;
      else      r = r >> 1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pool = 32'h1;
    m_cnt  = 0;
    m_run  = 0;
    m_prev = 8'h00;
    m_fail = 1'b0;
    q.delete();
  endtask

  task automatic model_accept(logic [7:0] raw);
    if (m_run != 0 && raw == m_prev)
      m_run = (m_run < 255) ? m_run + 1 : 255;
    else
      m_run = 1;
    m_prev = raw;
    if (m_run >= LIM) begin
      m_fail = 1'b1;
      q.delete();
    end
    m_pool = m_pool ^ {24'h0, raw};
    if (m_pool == 32'h0) m_pool = 32'h1;
    m_pool = mix8(m_pool);
    m_cnt++;
    if (m_cnt == SPB) begin
      m_cnt = 0;
      if (!m_fail && q.size() < DEP) q.push_back(m_pool[7:0]);
    end
  endtask

  task automatic drive_raw(logic [7:0] raw);
    logic [7:0] hx;
    logic [7:0] hy;
    hx = 8'($urandom);
    hy = 8'($urandom);
    x = {hx, raw[7:4], 4'h0};
    y = {hy, raw[3:0], 4'h0};
    sample_valid = 1'b1;
  endtask

  task automatic capture(logic [7:0] raw);
    @(negedge clk);
    drive_raw(raw);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    model_accept(raw);
  endtask

  task automatic send(logic [7:0] raw);
    capture(raw);
    repeat (19) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(string name);
    int t;
    out_ready = 1'b1;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  // Output checker against the model.
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (m_fail) check("valid_hf", 32'(out_valid), 32'd0);
      if (pv && !pr && out_valid)
        check("stable", 32'(out_data), 32'(pd));
      if (out_valid && out_ready) begin
        n_pop++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %h want none",
                   out_data);
        end else begin
          check("byte", 32'(out_data), 32'(q.pop_front()));
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    model_reset();

    // Reset state
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_hf", 32'(health_fail), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // One byte from four samples; latency of 9 edges
    out_ready = 1'b0;
    @(negedge clk);
    x = 16'h00A0;
    y = 16'h0050;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    model_accept(8'hA5);
    repeat (19) @(negedge clk);
    send(8'h3C);
    send(8'h71);
    capture(8'h0F);
    check("lit_byte", 32'(q[0]), 32'h06);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1 check($sformatf("lat_%0d", k), 32'(out_valid),
               (k == 9) ? 32'd1 : 32'd0);
    end
    p0 = n_pop;
    drain("one");
    check("one_pops", 32'(n_pop - p0), 32'd1);

    // Zero pool is forced to one
    do_reset();
    capture(8'h01);
    check("lit_pool", m_pool, 32'h0146_0000);
    repeat (19) @(negedge clk);
    send(8'h12);
    send(8'h34);
    send(8'h56);
    drain("zero");

    // Overrun during MIX
    do_reset();
    capture(8'h9A);
    check("ovr_before", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    drive_raw(8'hE7);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (30) @(negedge clk);
    check("ovr_nobyte", 32'(out_valid), 32'd0);
    send(8'h2B);
    send(8'hC4);
    send(8'h6D);
    drain("ovr");
    check("ovr_sticky", 32'(overrun), 32'd1);

    // FIFO overflow with stalled consumer
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(8'(i * 37 + 11));
    check("ovf_held", 32'(q.size()), 32'd4);
    check("ovf_valid", 32'(out_valid), 32'd1);
    p0 = n_pop;
    drain("ovf");
    check("ovf_pops", 32'(n_pop - p0), 32'd4);

    // Repetition health test
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(8'h55);
    check("hf_before", 32'(health_fail), 32'd0);
    check("hf_held", 32'(out_valid), 32'd1);
    capture(8'h55);
    check("hf_set", 32'(health_fail), 32'd1);
    check("hf_novalid", 32'(out_valid), 32'd0);
    repeat (19) @(negedge clk);
    for (int i = 0; i < 4; i++) send(8'h55);
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("hf_still", 32'(health_fail), 32'd1);
    check("hf_off", 32'(out_valid), 32'd0);

    // Asynchronous reset during MIX
    do_reset();
    out_ready = 1'b0;
    send(8'h81);
    send(8'h42);
    send(8'h93);
    send(8'h24);
    check("ar_held", 32'(out_valid), 32'd1);
    send(8'hB5);
    send(8'h66);
    send(8'hD7);
    capture(8'h18);
    @(negedge clk);
    drive_raw(8'h00);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    check("ar_ovr", 32'(overrun), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_data", 32'(out_data), 32'd0);
    check("ar_ovr0", 32'(overrun), 32'd0);
    check("ar_hf", 32'(health_fail), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("ar_nobyte", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(8'h18);
    send(8'h29);
    send(8'h3A);
    send(8'h4B);
    drain("ar");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
